input_debouncer_3ch: RTL and testbench
======================================

// Module: input_debouncer_3ch
// PURPOSE
//   Front end for the 3-bit priority encoder. Takes three raw, asynchronous
//   switch/button inputs and synchronises each one to clk. Debounces each
//   input with its own counter. Delivers clean levels a_db/b_db/c_db that drive
//   the encoder's a/b/c inputs directly, plus per-channel edge pulses and a
//   settled flag.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive cycles a new level must persist before it is accepted (>=2)
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//   clk      in   1  single clock; all state updates on rising edge
//   rst      in   1  synchronous, active-high reset
//   raw_a    in   1  asynchronous raw input, channel a (encoder highest priority)
//   raw_b    in   1  asynchronous raw input, channel b
//   raw_c    in   1  asynchronous raw input, channel c (lowest priority)
//   a_db     out  1  debounced level, channel a
//   b_db     out  1  debounced level, channel b
//   c_db     out  1  debounced level, channel c
//   rise     out  3  {a,b,c} one-cycle pulse when the debounced level goes 0->1
//   fall     out  3  {a,b,c} one-cycle pulse when the debounced level goes 1->0
//   settled  out  1  1 = no channel has a pending, unaccepted change
// BEHAVIOUR
//   Reset (rst=1 at a clk edge):
//     - Sync flops, counters, a_db/b_db/c_db, rise and fall all go to 0.
//     - settled goes to 1.
//     - rst overrides all other activity, including a count in progress; the
//       partial count is discarded.
//   Synchroniser: two flops per channel (s1 <= raw, s2 <= s1). Only s2 is used.
//   Per-channel counter, evaluated each edge with lvl = the channel's *_db:
//     - s2 == lvl: cnt <= 0. Any bounce restarts qualification from zero.
//     - s2 != lvl and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//     - s2 != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s2, cnt <= 0, and the
//       matching rise/fall bit is set for exactly that one cycle.
//   Latency:
//     - A raw change first sampled by s1 at edge k, then held, appears on *_db
//       after edge k+1+DEBOUNCE_CYCLES.
//     - That is DEBOUNCE_CYCLES+2 edges counting edge k itself.
//   Glitch rejection: a change that lasts fewer than DEBOUNCE_CYCLES cycles at
//     s2 never reaches *_db and produces no pulse.
//   Pulses:
//     - rise/fall are registered and high for exactly one cycle.
//     - rise[i] and fall[i] are never both 1.
//     - Different channels may pulse in the same cycle.
//   settled:
//     - Registered.
//     - Next value = 1 when, for every channel, s2 == lvl and cnt == 0 after the
//       edge's updates; otherwise 0.
//   Simultaneous events: channels are fully independent. Changes on several
//     channels in the same cycle are accepted in the same cycle.
//   Wrap-around: counters never pass DEBOUNCE_CYCLES-1; they stop there and
//     clear to 0.
//   The block applies no priority; it only delivers clean levels and leaves
//     priority encoding to the encoder.
// TESTING  (DEBOUNCE_CYCLES=16)
//   1. Reset: hold rst for 3 cycles with raw=111.
//      -> *_db=0, rise=fall=0, settled=1 throughout. After release, a_db/b_db/c_db
//         reach 1 at edge 18 and rise=3'b111 for one cycle.
//   2. Steady press: raw_a 0->1 and held.
//      -> a_db=1 exactly 18 edges later; rise=3'b100 for 1 cycle; settled=0 in
//         between and 1 the cycle after acceptance.
//   3. Bounce: raw_b toggles 1/0 every 3 cycles for 30 cycles, then settles at 1.
//      -> b_db stays 0 during the bouncing; it goes to 1 only 18 edges after the
//         final transition; a single rise pulse.
//   4. Short glitch: raw_c high for 15 cycles, then low.
//      -> c_db never changes; no pulse; settled returns to 1.
//   5. Simultaneous release: from a_db=b_db=c_db=1, all raw go to 0 on the same
//      cycle.
//      -> all three *_db fall on the same edge; fall=3'b111 for one cycle.
//   6. Reset mid-count: raw_a held 1 for 10 cycles, then rst for 1 cycle, raw_a
//      still held.
//      -> a_db stays 0. Counting restarts and a_db=1 at 18 edges after release of rst.

Source files
------------

// File: rtl/input_debouncer_3ch.sv
// Three-channel switch front end: 2-flop sync, per-channel debounce counter,
// registered clean levels, edge pulses and an all-quiet flag.
module input_debouncer_3ch #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       raw_a,
   input  logic       raw_b,
   input  logic       raw_c,
   output logic       a_db,
   output logic       b_db,
   output logic       c_db,
   output logic [2:0] rise,
   output logic [2:0] fall,
   output logic       settled
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       s1_q, s1_d;
   logic [2:0]       s2_q, s2_d;
   logic [2:0]       db_q, db_d;
   logic [2:0]       rise_q, rise_d;
   logic [2:0]       fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic             settled_q, settled_d;

   // Bit 2 = a, bit 1 = b, bit 0 = c throughout.
   always_comb begin
      s1_d      = {raw_a, raw_b, raw_c};
      s2_d      = s1_q;
      db_d      = db_q;
      rise_d    = '0;
      fall_d    = '0;
      settled_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               db_d[i]   = s2_q[i];
               rise_d[i] = s2_q[i];
               fall_d[i] = ~s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
         if ((s2_d[i] != db_d[i]) || (cnt_d[i] != '0)) begin
            settled_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         db_q      <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         cnt_q     <= '{default: '0};
         settled_q <= 1'b1;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         db_q      <= db_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         cnt_q     <= cnt_d;
         settled_q <= settled_d;
      end
   end

   assign a_db    = db_q[2];
   assign b_db    = db_q[1];
   assign c_db    = db_q[0];
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign settled = settled_q;

endmodule

// File: tb/tb_input_debouncer_3ch.sv
// Randomized and scenario bench for input_debouncer_3ch against a
// sample-window reference model.
module tb_input_debouncer_3ch;

   localparam int DC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       raw_a, raw_b, raw_c;
   logic       a_db, b_db, c_db;
   logic [2:0] rise, fall;
   logic       settled;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   input_debouncer_3ch #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk     (clk),
      .rst     (rst),
      .raw_a   (raw_a),
      .raw_b   (raw_b),
      .raw_c   (raw_c),
      .a_db    (a_db),
      .b_db    (b_db),
      .c_db    (c_db),
      .rise    (rise),
      .fall    (fall),
      .settled (settled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a level is accepted once the last DC samples seen at the
   // second sync stage (since the previous acceptance or reset) all differ
   // from the current clean level.
   logic [2:0]    m_s1, m_s2, m_db, m_rise, m_fall;
   logic          m_set;
   logic [DC-1:0] win [3];
   int            nsamp [3];

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_db = '0;
         m_rise = '0; m_fall = '0; m_set = 1'b1;
         for (int i = 0; i < 3; i++) begin
            win[i] = '0;
            nsamp[i] = 0;
         end
      end else begin
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < 3; i++) begin
            win[i] = {win[i][DC-2:0], m_s2[i]};
            nsamp[i]++;
            if (nsamp[i] >= DC && win[i] == {DC{~m_db[i]}}) begin
               m_db[i] = ~m_db[i];
               if (m_db[i]) m_rise[i] = 1'b1;
               else m_fall[i] = 1'b1;
               nsamp[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = {raw_a, raw_b, raw_c};
         m_set = 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_db[i]) m_set = 1'b0;
            if (nsamp[i] > 0 && win[i][0] != m_db[i]) m_set = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("db", {29'd0, a_db, b_db, c_db}, {29'd0, m_db});
         chk("rise", {29'd0, rise}, {29'd0, m_rise});
         chk("fall", {29'd0, fall}, {29'd0, m_fall});
         chk("settled", {31'd0, settled}, {31'd0, m_set});
         chk("excl", {29'd0, rise & fall}, 32'd0);
      end
   end

   task automatic set_raw(input logic [2:0] v);
      {raw_a, raw_b, raw_c} = v;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts edges until the masked clean levels equal want (bounded).
   task automatic measure(input logic [2:0] want, input logic [2:0] mask,
                          output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while ((({a_db, b_db, c_db} & mask) != (want & mask)) && n < 60);
   endtask

   int lat;

   initial begin
      rst = 1'b1;
      set_raw(3'b111);
      @(posedge clk);
      #1 mon_en = 1'b1;
      cycles(3);
      chk("rst_db", {29'd0, a_db, b_db, c_db}, 32'd0);
      chk("rst_settled", {31'd0, settled}, 32'd1);

      rst = 1'b0;
      measure(3'b111, 3'b111, lat);
      chk("t1_lat", lat, 18);
      chk("t1_rise", {29'd0, rise}, 32'd7);
      @(negedge clk);

      set_raw(3'b000);
      measure(3'b000, 3'b111, lat);
      chk("t5_lat", lat, 18);
      chk("t5_fall", {29'd0, fall}, 32'd7);
      @(negedge clk);

      set_raw(3'b100);
      measure(3'b100, 3'b100, lat);
      chk("t2_lat", lat, 18);
      chk("t2_rise", {29'd0, rise}, 32'd4);
      @(negedge clk);
      chk("t2_settled", {31'd0, settled}, 32'd1);

      for (int k = 0; k < 10; k++) begin
         raw_b = (k % 2 == 0);
         cycles(3);
      end
      chk("t3_bounce_db", {31'd0, b_db}, 32'd0);
      raw_b = 1'b1;
      measure(3'b010, 3'b010, lat);
      chk("t3_lat", lat, 18);
      chk("t3_rise", {29'd0, rise}, 32'd2);
      @(negedge clk);

      raw_c = 1'b1;
      cycles(15);
      raw_c = 1'b0;
      cycles(25);
      chk("t4_c_db", {31'd0, c_db}, 32'd0);
      chk("t4_settled", {31'd0, settled}, 32'd1);

      set_raw(3'b000);
      cycles(25);
      raw_a = 1'b1;
      cycles(10);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      chk("t6_a_db", {31'd0, a_db}, 32'd0);
      measure(3'b100, 3'b100, lat);
      chk("t6_lat", lat, 18);
      @(negedge clk);

      for (int s = 0; s < 150; s++) begin
         set_raw(3'($urandom));
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            cycles(1);
            rst = 1'b0;
         end
         cycles($urandom_range(1, 24));
      end

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
